// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter sharing one HPS SD block port among SUBDRV track-buffer requesters.
// Grant one cycle after a request is seen; strobe held until sd_ack; requesters wait on done, with a watchdog abort.
module ieeedrv_sd_arb #(
  parameter int          SUBDRV  = 2,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [SUBDRV-1:0]       req_rd,
  input  logic [SUBDRV-1:0]       req_wr,
  input  logic [SUBDRV-1:0][31:0] req_lba,
  input  logic [SUBDRV-1:0][5:0]  req_blk_cnt,
  output logic [SUBDRV-1:0]       done,
  output logic [SUBDRV-1:0]       err,
  output logic [SUBDRV-1:0]       drv_busy,
  output logic [SUBDRV-1:0]       drv_ack,
  output logic [SUBDRV-1:0]       drv_buff_wr,
  output logic [31:0]             sd_lba,
  output logic [5:0]              sd_blk_cnt,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack,
  input  logic                    sd_buff_wr
);
  localparam int GW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
    logic [5:0]  blk_cnt;
  } cmd_t;

  state_t            state, state_nxt;
  cmd_t              cmd;
  logic [GW-1:0]     gnt, rr, pick_idx;
  logic              pick_vld;
  logic [SUBDRV-1:0] pending, gnt_oh;
  logic [23:0]       cnt;
  logic              ack_q, ack_rise, cnt_hit, timed_out, to_nxt, port_own;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= SUBDRV) s = s - SUBDRV;
    return GW'(s);
  endfunction

  assign pending    = req_rd | req_wr;
  assign ack_rise   = sd_ack & ~ack_q;
  assign cnt_hit    = (cnt == TIMEOUT - 24'd1);
  assign sd_lba     = cmd.lba;
  assign sd_blk_cnt = cmd.blk_cnt;

  // Scan from the highest offset down so the nearest pending drive at/after rr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr;
    for (int k = SUBDRV - 1; k >= 0; k--) begin
      if (pending[wrap_idx(rr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(rr, k);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < SUBDRV; i++) gnt_oh[i] = (gnt == GW'(i));
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = 1'b0;
    case (state)
      IDLE:  if (pick_vld) state_nxt = ISSUE;
      ISSUE: begin
        if (ack_rise) state_nxt = XFER;
        else if (cnt_hit) begin
          state_nxt = DONE;
          to_nxt    = 1'b1;
        end
      end
      XFER: begin
        if (!sd_ack) state_nxt = DONE;
        else if (cnt_hit) begin
          state_nxt = DONE;
          to_nxt    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    port_own    = (state == ISSUE) || (state == XFER);
    // Strobe drops combinationally in the very cycle the ack edge is first seen.
    sd_rd       = (state == ISSUE) && !cmd.wr && !ack_rise;
    sd_wr       = (state == ISSUE) && cmd.wr && !ack_rise;
    drv_busy    = port_own ? gnt_oh : '0;
    drv_ack     = (port_own && sd_ack) ? gnt_oh : '0;
    drv_buff_wr = (port_own && sd_ack && sd_buff_wr) ? gnt_oh : '0;
    done        = (state == DONE) ? gnt_oh : '0;
    err         = (state == DONE && timed_out) ? gnt_oh : '0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      rr        <= '0;
      cmd       <= '0;
      cnt       <= '0;
      ack_q     <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      ack_q <= sd_ack;
      if (state != state_nxt)  cnt <= '0;
      else if (cnt != 24'hFFFFFF) cnt <= cnt + 24'd1;
      if (state == IDLE && pick_vld) begin
        gnt         <= pick_idx;
        cmd.wr      <= req_wr[pick_idx];
        cmd.lba     <= req_lba[pick_idx];
        cmd.blk_cnt <= req_blk_cnt[pick_idx];
      end
      if (state != DONE) timed_out <= to_nxt;
      if (state == DONE) rr <= (gnt == GW'(SUBDRV - 1)) ? '0 : gnt + GW'(1);
    end
  end
endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Bench for ieeedrv_sd_arb: directed scenarios plus randomized round-robin traffic against a rule-level model.
// dut_s uses a short watchdog (16); dut_l a long one so long bursts fit, both share the same stimulus.
module tb_ieeedrv_sd_arb;
  localparam int          N    = 2;
  localparam logic [23:0] TO_S = 24'd16;
  localparam logic [23:0] TO_L = 24'd1000;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [N-1:0]       req_rd, req_wr;
  logic [N-1:0][31:0] req_lba;
  logic [N-1:0][5:0]  req_blk_cnt;
  logic               sd_ack, sd_buff_wr;

  logic [N-1:0] done_s, err_s, busy_s, ack_s, bw_s;
  logic [31:0]  sd_lba_s;
  logic [5:0]   sd_blk_cnt_s;
  logic         sd_rd_s, sd_wr_s;
  logic [N-1:0] done_l, err_l, busy_l, ack_l, bw_l;
  logic [31:0]  sd_lba_l;
  logic [5:0]   sd_blk_cnt_l;
  logic         sd_rd_l, sd_wr_l;

  int checks   = 0;
  int failures = 0;
  int done_cnt [N] = '{default: 0};
  int err_cnt  [N] = '{default: 0};
  int bwl_cnt  [N] = '{default: 0};

  always #5 clk_sys = ~clk_sys;

  ieeedrv_sd_arb #(.SUBDRV(N), .TIMEOUT(TO_S)) dut_s (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_lba(req_lba), .req_blk_cnt(req_blk_cnt), .done(done_s), .err(err_s),
    .drv_busy(busy_s), .drv_ack(ack_s), .drv_buff_wr(bw_s), .sd_lba(sd_lba_s),
    .sd_blk_cnt(sd_blk_cnt_s), .sd_rd(sd_rd_s), .sd_wr(sd_wr_s),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr));

  ieeedrv_sd_arb #(.SUBDRV(N), .TIMEOUT(TO_L)) dut_l (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_lba(req_lba), .req_blk_cnt(req_blk_cnt), .done(done_l), .err(err_l),
    .drv_busy(busy_l), .drv_ack(ack_l), .drv_buff_wr(bw_l), .sd_lba(sd_lba_l),
    .sd_blk_cnt(sd_blk_cnt_l), .sd_rd(sd_rd_l), .sd_wr(sd_wr_l),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr));

  always @(negedge clk_sys) begin
    for (int i = 0; i < N; i++) begin
      if (done_s[i]) done_cnt[i]++;
      if (err_s[i])  err_cnt[i]++;
      if (bw_l[i])   bwl_cnt[i]++;
    end
  end

  task automatic next_cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req_rd = '0; req_wr = '0; req_lba = '0; req_blk_cnt = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (3) next_cyc();
    reset_n = 1'b1;
    next_cyc();
  endtask

  // HPS side plus requester side of one transfer on dut_s; reports what was seen.
  task automatic xfer_s(input int dly, input int len, output bit ok,
                        output logic [N-1:0] busy_o, output logic wr_o,
                        output logic [31:0] lba_o, output logic [5:0] cnt_o,
                        output logic [N-1:0] done_o, output logic [N-1:0] err_o);
    int n;
    ok = 1'b0; busy_o = '0; wr_o = 1'b0; lba_o = '0; cnt_o = '0; done_o = '0; err_o = '0;
    n = 0;
    @(negedge clk_sys);
    while (!(sd_rd_s || sd_wr_s) && n < 40) begin @(negedge clk_sys); n++; end
    if (!(sd_rd_s || sd_wr_s)) return;
    busy_o = busy_s; wr_o = sd_wr_s; lba_o = sd_lba_s; cnt_o = sd_blk_cnt_s;
    for (int i = 0; i < dly; i++) @(negedge clk_sys);
    next_cyc();
    sd_ack = 1'b1;
    for (int i = 0; i < len; i++) begin
      sd_buff_wr = 1'($urandom_range(0, 1));
      next_cyc();
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    n = 0;
    @(negedge clk_sys);
    while (done_s == '0 && n < 5) begin @(negedge clk_sys); n++; end
    done_o = done_s; err_o = err_s;
    if (done_s == '0) return;
    next_cyc();
    for (int d = 0; d < N; d++) begin
      if (done_o[d]) begin
        if (wr_o) req_wr[d] = 1'b0;
        else      req_rd[d] = 1'b0;
      end
    end
    ok = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0; req_rd = 2'b11; req_wr = 2'b01; req_lba = {32'd5, 32'd9};
    req_blk_cnt = '1; sd_ack = 1'b1; sd_buff_wr = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({done_s, err_s, busy_s, ack_s, bw_s} !== '0)
      $display("FAIL reset_drv_outs: got %b want all 0", {done_s, err_s, busy_s, ack_s, bw_s});
    checks++;
    if ({sd_rd_s, sd_wr_s} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes: got %b want 00", {sd_rd_s, sd_wr_s});
    end
    checks++;
    if (sd_lba_s !== 32'd0 || sd_blk_cnt_s !== 6'd0) begin
      failures++; $display("FAIL reset_lba: got lba=%0d cnt=%0d want 0/0", sd_lba_s, sd_blk_cnt_s);
    end
    if ({done_s, err_s, busy_s, ack_s, bw_s} !== '0) failures++;
    next_cyc();
    req_rd = '0; req_wr = '0; reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    checks++;
    if ({busy_s, ack_s, bw_s, done_s} !== '0 || sd_rd_s !== 1'b0) begin
      failures++; $display("FAIL stale_ack_idle: got busy=%b ack=%b bw=%b want 0", busy_s, ack_s, bw_s);
    end
    next_cyc();
    req_rd = 2'b01;
    n = 1;
    @(negedge clk_sys);
    while (!sd_rd_s && n < 4) begin @(negedge clk_sys); n++; end
    checks++;
    if (sd_rd_s !== 1'b1 || n > 2) begin
      failures++; $display("FAIL stale_ack_grant: sd_rd=%b after %0d cycles want 1 within 2", sd_rd_s, n);
    end
  endtask

  task automatic test_single_read();
    int n, b0, b1, e0;
    apply_reset();
    b0 = done_cnt[0]; b1 = done_cnt[1]; e0 = err_cnt[0];
    req_lba[0] = 32'd357; req_blk_cnt[0] = 6'd3; req_rd = 2'b01;
    n = 1;
    @(negedge clk_sys);
    while (!sd_rd_s && n < 4) begin @(negedge clk_sys); n++; end
    checks++;
    if (sd_rd_s !== 1'b1 || n > 2) begin
      failures++; $display("FAIL t1_issue: sd_rd=%b after %0d cycles want 1 within 2", sd_rd_s, n);
    end
    checks++;
    if (sd_lba_s !== 32'd357 || sd_blk_cnt_s !== 6'd3 || sd_wr_s !== 1'b0 || busy_s !== 2'b01) begin
      failures++; $display("FAIL t1_cmd: got lba=%0d cnt=%0d wr=%b busy=%b want 357/3/0/01",
                           sd_lba_s, sd_blk_cnt_s, sd_wr_s, busy_s);
    end
    repeat (3) @(negedge clk_sys);
    checks++;
    if (sd_rd_s !== 1'b1) begin
      failures++; $display("FAIL t1_hold: sd_rd=%b want 1 while waiting for ack", sd_rd_s);
    end
    next_cyc();
    sd_ack = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (sd_rd_s !== 1'b0 || ack_s !== 2'b01) begin
      failures++; $display("FAIL t1_ack_edge: got sd_rd=%b drv_ack=%b want 0/01", sd_rd_s, ack_s);
    end
    repeat (9) next_cyc();
    sd_ack = 1'b0;
    n = 0;
    @(negedge clk_sys);
    while (done_s == '0 && n < 4) begin @(negedge clk_sys); n++; end
    checks++;
    if (done_s !== 2'b01 || err_s !== 2'b00) begin
      failures++; $display("FAIL t1_done: got done=%b err=%b want 01/00", done_s, err_s);
    end
    next_cyc();
    req_rd = '0;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (done_cnt[0] - b0 !== 1 || done_cnt[1] - b1 !== 0 || err_cnt[0] - e0 !== 0 || busy_s !== 2'b00) begin
      failures++; $display("FAIL t1_once: got done0=%0d done1=%0d err0=%0d busy=%b want 1/0/0/00",
                           done_cnt[0] - b0, done_cnt[1] - b1, err_cnt[0] - e0, busy_s);
    end
  endtask

  task automatic test_contention();
    bit ok; logic [N-1:0] b, d, e; logic w; logic [31:0] l; logic [5:0] c;
    apply_reset();
    req_lba[0] = 32'd100; req_lba[1] = 32'd200; req_rd = 2'b11;
    xfer_s(2, 4, ok, b, w, l, c, d, e);
    checks++;
    if (!ok || b !== 2'b01 || l !== 32'd100 || d !== 2'b01) begin
      failures++; $display("FAIL t2_first: got ok=%0d busy=%b lba=%0d done=%b want 1/01/100/01", ok, b, l, d);
    end
    req_rd[0] = 1'b1;
    xfer_s(1, 3, ok, b, w, l, c, d, e);
    checks++;
    if (!ok || b !== 2'b10 || l !== 32'd200 || d !== 2'b10) begin
      failures++; $display("FAIL t2_second: got ok=%0d busy=%b lba=%0d done=%b want 1/10/200/10", ok, b, l, d);
    end
    xfer_s(0, 2, ok, b, w, l, c, d, e);
    checks++;
    if (!ok || b !== 2'b01 || l !== 32'd100 || d !== 2'b01) begin
      failures++; $display("FAIL t2_third: got ok=%0d busy=%b lba=%0d done=%b want 1/01/100/01", ok, b, l, d);
    end
  endtask

  task automatic test_wr_before_rd();
    bit ok; logic [N-1:0] b, d, e; logic w; logic [31:0] l; logic [5:0] c;
    apply_reset();
    req_lba[1] = 32'd777; req_blk_cnt[1] = 6'd9; req_wr = 2'b10; req_rd = 2'b10;
    xfer_s(1, 5, ok, b, w, l, c, d, e);
    checks++;
    if (!ok || w !== 1'b1 || b !== 2'b10 || l !== 32'd777 || c !== 6'd9) begin
      failures++; $display("FAIL t3_write_first: got ok=%0d wr=%b busy=%b lba=%0d cnt=%0d want 1/1/10/777/9",
                           ok, w, b, l, c);
    end
    xfer_s(2, 3, ok, b, w, l, c, d, e);
    checks++;
    if (!ok || w !== 1'b0 || b !== 2'b10 || d !== 2'b10 || e !== 2'b00) begin
      failures++; $display("FAIL t3_read_second: got ok=%0d wr=%b busy=%b done=%b err=%b want 1/0/10/10/00",
                           ok, w, b, d, e);
    end
  endtask

  task automatic test_timeout();
    int n, iss, b0;
    apply_reset();
    b0 = done_cnt[0];
    req_lba[0] = $urandom; req_rd = 2'b01;
    n = 0;
    @(negedge clk_sys);
    while (!sd_rd_s && n < 4) begin @(negedge clk_sys); n++; end
    iss = sd_rd_s ? 1 : 0;
    next_cyc();
    req_rd = '0;
    n = 0;
    while (n < 40) begin
      @(negedge clk_sys);
      n++;
      if (done_s != '0) break;
      if (sd_rd_s) iss++;
    end
    checks++;
    if (iss !== 16) begin
      failures++; $display("FAIL t4_issue_len: got %0d strobe cycles want 16", iss);
    end
    checks++;
    if (done_s !== 2'b01 || err_s !== 2'b01 || sd_rd_s !== 1'b0) begin
      failures++; $display("FAIL t4_abort: got done=%b err=%b sd_rd=%b want 01/01/0", done_s, err_s, sd_rd_s);
    end
    repeat (4) @(negedge clk_sys);
    checks++;
    if (done_cnt[0] - b0 !== 1 || busy_s !== 2'b00) begin
      failures++; $display("FAIL t4_after: got done0=%0d busy=%b want 1/00", done_cnt[0] - b0, busy_s);
    end
  endtask

  task automatic test_steering();
    int n, b0, b1;
    logic [31:0] lba;
    apply_reset();
    b0 = bwl_cnt[0]; b1 = bwl_cnt[1];
    lba = $urandom;
    req_lba[1] = lba; req_blk_cnt[1] = 6'd63; req_rd = 2'b10;
    n = 0;
    @(negedge clk_sys);
    while (!sd_rd_l && n < 4) begin @(negedge clk_sys); n++; end
    checks++;
    if (sd_rd_l !== 1'b1 || busy_l !== 2'b10 || sd_lba_l !== lba || sd_blk_cnt_l !== 6'd63 || sd_wr_l !== 1'b0) begin
      failures++; $display("FAIL t5_grant: got rd=%b busy=%b lba=%h cnt=%0d want 1/10/%h/63",
                           sd_rd_l, busy_l, sd_lba_l, sd_blk_cnt_l, lba);
    end
    next_cyc();
    req_rd[0] = 1'b1; sd_ack = 1'b1; sd_buff_wr = 1'b1;
    repeat (256) next_cyc();
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (ack_l !== 2'b10) begin
      failures++; $display("FAIL t5_ack_route: got drv_ack=%b want 10", ack_l);
    end
    next_cyc();
    sd_ack = 1'b0;
    n = 0;
    @(negedge clk_sys);
    while (done_l == '0 && n < 4) begin @(negedge clk_sys); n++; end
    checks++;
    if (done_l !== 2'b10 || err_l !== 2'b00) begin
      failures++; $display("FAIL t5_done: got done=%b err=%b want 10/00", done_l, err_l);
    end
    next_cyc();
    req_rd = '0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (bwl_cnt[1] - b1 !== 256 || bwl_cnt[0] - b0 !== 0) begin
      failures++; $display("FAIL t5_counts: got bw1=%0d bw0=%0d want 256/0", bwl_cnt[1] - b1, bwl_cnt[0] - b0);
    end
  endtask

  task automatic test_async_reset();
    int n, b0, b1;
    apply_reset();
    b0 = done_cnt[0]; b1 = done_cnt[1];
    req_wr = 2'b01; req_lba[0] = 32'h1234;
    n = 0;
    @(negedge clk_sys);
    while (!sd_wr_s && n < 4) begin @(negedge clk_sys); n++; end
    next_cyc();
    sd_ack = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (busy_s !== 2'b01 || ack_s !== 2'b01) begin
      failures++; $display("FAIL t6_in_xfer: got busy=%b ack=%b want 01/01", busy_s, ack_s);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy_s !== 2'b00 || ack_s !== 2'b00 || sd_rd_s !== 1'b0 || sd_wr_s !== 1'b0) begin
      failures++; $display("FAIL t6_xfer_reset: got busy=%b ack=%b rd=%b wr=%b want 0", busy_s, ack_s, sd_rd_s, sd_wr_s);
    end
    sd_ack = 1'b0;
    next_cyc();
    reset_n = 1'b1;
    n = 0;
    @(negedge clk_sys);
    while (!sd_wr_s && n < 4) begin @(negedge clk_sys); n++; end
    checks++;
    if (sd_wr_s !== 1'b1) begin
      failures++; $display("FAIL t6_regrant: got sd_wr=%b want 1", sd_wr_s);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (sd_wr_s !== 1'b0 || busy_s !== 2'b00) begin
      failures++; $display("FAIL t6_issue_reset: got sd_wr=%b busy=%b want 0/00", sd_wr_s, busy_s);
    end
    req_wr = '0;
    repeat (2) next_cyc();
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    checks++;
    if (done_cnt[0] - b0 !== 0 || done_cnt[1] - b1 !== 0) begin
      failures++; $display("FAIL t6_no_done: got done0=%0d done1=%0d want 0/0", done_cnt[0] - b0, done_cnt[1] - b1);
    end
  endtask

  // Model: grant = first requesting drive at/after the pointer; pointer moves past the served drive.
  task automatic test_random();
    bit ok; logic [N-1:0] b, d, e, pend, oh; logic w; logic [31:0] l; logic [5:0] c;
    int rr_m, exp_d;
    logic exp_wr; logic [31:0] exp_lba; logic [5:0] exp_cnt;
    apply_reset();
    rr_m = 0;
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_rd[k] && !req_wr[k]) begin
          req_lba[k]     = $urandom;
          req_blk_cnt[k] = 6'($urandom);
          req_rd[k]      = 1'($urandom_range(0, 1));
          req_wr[k]      = 1'($urandom_range(0, 1));
        end
      end
      pend = req_rd | req_wr;
      if (pend == '0) continue;
      exp_d = -1;
      for (int k = 0; k < N; k++)
        if (exp_d < 0 && pend[(rr_m + k) % N]) exp_d = (rr_m + k) % N;
      oh = '0; oh[exp_d] = 1'b1;
      exp_wr = req_wr[exp_d]; exp_lba = req_lba[exp_d]; exp_cnt = req_blk_cnt[exp_d];
      xfer_s($urandom_range(0, 5), $urandom_range(1, 10), ok, b, w, l, c, d, e);
      checks++;
      if (!ok || b !== oh || w !== exp_wr || l !== exp_lba || c !== exp_cnt || d !== oh || e !== '0) begin
        failures++;
        $display("FAIL rand_%0d: got ok=%0d busy=%b wr=%b lba=%h cnt=%0d done=%b err=%b want busy=%b wr=%b lba=%h cnt=%0d",
                 r, ok, b, w, l, c, d, e, oh, exp_wr, exp_lba, exp_cnt);
      end
      rr_m = (exp_d + 1) % N;
    end
  endtask

  initial begin
    reset_n = 1'b0; req_rd = '0; req_wr = '0; req_lba = '0; req_blk_cnt = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_wr_before_rd();
    test_timeout();
    test_steering();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end
endmodule
